// File: rtl/vram_console_writer_if.sv
// Byte-stream input, VRAM port A and cursor/status bundle for the console writer.
// master = byte source / VRAM owner side, slave = console writer.
interface vram_console_writer_if #(
    parameter int DATA = 8,
    parameter int ADDR = 13
);
    logic            in_valid;
    logic [DATA-1:0] in_data;
    logic            in_ready;
    logic            mem_wr;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_din;
    logic [DATA-1:0] mem_dout;
    logic [6:0]      cursor_x;
    logic [5:0]      cursor_y;
    logic            busy;

    modport master (
        output in_valid, in_data, mem_dout,
        input  in_ready, mem_wr, mem_addr, mem_din, cursor_x, cursor_y, busy
    );

    modport slave (
        input  in_valid, in_data, mem_dout,
        output in_ready, mem_wr, mem_addr, mem_din, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/vram_console_writer.sv
// Character-terminal front end: interprets a byte stream, writes glyphs at the cursor,
// and performs clear-screen and one-line scroll through VRAM port A.
module vram_console_writer #(
    parameter int              COLS  = 80,
    parameter int              ROWS  = 60,
    parameter int              DATA  = 8,
    parameter int              ADDR  = 13,
    parameter logic [DATA-1:0] BLANK = 8'h20
) (
    input logic                 clk,
    input logic                 rst,
    vram_console_writer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_BLANK} state_t;

    localparam logic [ADDR-1:0] L_COLS     = ADDR'(COLS);
    localparam logic [ADDR-1:0] L_LAST     = ADDR'(COLS * ROWS - 1);
    localparam logic [ADDR-1:0] L_LAST_ROW = ADDR'(COLS * (ROWS - 1));
    localparam logic [6:0]      L_XMAX     = 7'(COLS - 1);
    localparam logic [5:0]      L_YMAX     = 6'(ROWS - 1);

    state_t          r_state;
    logic [ADDR-1:0] r_cnt;
    logic            r_wr;
    logic [ADDR-1:0] r_addr;
    logic [DATA-1:0] r_din;
    logic            r_pass;
    logic [6:0]      r_x;
    logic [5:0]      r_y;

    logic            w_accept;
    logic            w_print;
    logic [ADDR-1:0] w_cur_addr;

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_print    = (bus.in_data >= DATA'(8'h20)) && (bus.in_data <= DATA'(8'h7E));
    assign w_cur_addr = ADDR'(r_y) * L_COLS + ADDR'(r_x);

    // r_state names the action taken at the next edge, so each access becomes
    // visible one cycle after its state; busy/in_ready decode directly from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_din   <= BLANK;
            r_pass  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_wr   <= 1'b0;
            r_pass <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_print) begin
                            r_wr   <= 1'b1;
                            r_addr <= w_cur_addr;
                            r_din  <= bus.in_data;
                            if (r_x == L_XMAX) begin
                                r_x <= '0;
                                if (r_y == L_YMAX) begin
                                    r_state <= SCROLL_RD;
                                    r_cnt   <= L_COLS;
                                end else begin
                                    r_y <= r_y + 6'd1;
                                end
                            end else begin
                                r_x <= r_x + 7'd1;
                            end
                        end else begin
                            case (bus.in_data)
                                DATA'(8'h0A): begin
                                    r_x <= '0;
                                    if (r_y == L_YMAX) begin
                                        r_state <= SCROLL_RD;
                                        r_cnt   <= L_COLS;
                                    end else begin
                                        r_y <= r_y + 6'd1;
                                    end
                                end
                                DATA'(8'h0D): r_x <= '0;
                                DATA'(8'h08): begin
                                    if (r_x != 7'd0) begin
                                        r_x    <= r_x - 7'd1;
                                        r_wr   <= 1'b1;
                                        r_addr <= w_cur_addr - ADDR'(1);
                                        r_din  <= BLANK;
                                    end
                                end
                                DATA'(8'h0C): begin
                                    r_x     <= '0;
                                    r_y     <= '0;
                                    r_state <= CLEAR;
                                    r_cnt   <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLEAR: begin
                    r_wr   <= 1'b1;
                    r_addr <= r_cnt;
                    r_din  <= BLANK;
                    if (r_cnt == L_LAST) r_state <= IDLE;
                    else                 r_cnt   <= r_cnt + ADDR'(1);
                end
                SCROLL_RD: begin
                    r_addr  <= r_cnt;
                    r_state <= SCROLL_WR;
                end
                SCROLL_WR: begin
                    // Write data is the read result arriving this cycle, forwarded combinationally.
                    r_wr   <= 1'b1;
                    r_pass <= 1'b1;
                    r_addr <= r_cnt - L_COLS;
                    if (r_cnt == L_LAST) begin
                        r_state <= SCROLL_BLANK;
                        r_cnt   <= L_LAST_ROW;
                    end else begin
                        r_state <= SCROLL_RD;
                        r_cnt   <= r_cnt + ADDR'(1);
                    end
                end
                SCROLL_BLANK: begin
                    r_wr   <= 1'b1;
                    r_addr <= r_cnt;
                    r_din  <= BLANK;
                    if (r_cnt == L_LAST) r_state <= IDLE;
                    else                 r_cnt   <= r_cnt + ADDR'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = (r_state == IDLE);
    assign bus.busy     = (r_state != IDLE);
    assign bus.mem_wr   = r_wr;
    assign bus.mem_addr = r_addr;
    assign bus.mem_din  = r_pass ? bus.mem_dout : r_din;
    assign bus.cursor_x = r_x;
    assign bus.cursor_y = r_y;

endmodule

// File: tb/tb_vram_console_writer.sv
// Directed bench for vram_console_writer with a 4800-entry synchronous-read VRAM model.
module tb_vram_console_writer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vram_console_writer_if #(.DATA(8), .ADDR(13)) bus ();

    vram_console_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  vram [0:4799];
    logic [7:0]  r_dout;
    logic        bd_we   = 1'b0;
    logic [12:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    // VRAM model: read data appears the cycle after the address; backdoor port preloads.
    always @(posedge clk) begin
        if (bd_we)
            vram[bd_addr] <= bd_data;
        else if (bus.mem_wr && bus.mem_addr < 13'd4800)
            vram[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_addr < 13'd4800) r_dout <= vram[bus.mem_addr];
        else                         r_dout <= 8'hxx;
    end
    assign bus.mem_dout = r_dout;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int busy_cnt;
        int bad_k;
        int nblank;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.mem_addr !== 13'd0 || bus.mem_din !== 8'h20 ||
            bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: wr=%b addr=%0d din=%h busy=%b rdy=%b, want 0 0 20 1 0",
                     bus.mem_wr, bus.mem_addr, bus.mem_din, bus.busy, bus.in_ready);
        end
        n_cmp++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_cursor: (%0d,%0d), want (0,0)", bus.cursor_x, bus.cursor_y);
        end
        busy_cnt = 1;
        bad_k = -1;
        for (int k = 0; k < 4800; k++) begin
            step();
            if (bus.busy === 1'b1) busy_cnt++;
            if (bad_k < 0 && (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'(k) ||
                              bus.mem_din !== 8'h20 || (k < 4799 && bus.in_ready !== 1'b0)))
                bad_k = k;
        end
        n_cmp++;
        if (bad_k != -1) begin
            n_bad++;
            $display("FAIL clear_sequence: first bad write index %0d (wr=%b addr=%0d din=%h), want 0x20 at ascending addr",
                     bad_k, bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        n_cmp++;
        if (busy_cnt != 4800 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_busy_len: busy cycles=%0d rdy=%b, want 4800 and 1", busy_cnt, bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd0) begin
            n_bad++;
            $display("FAIL clear_done: wr=%b cursor (%0d,%0d), want 0 (0,0)", bus.mem_wr, bus.cursor_x, bus.cursor_y);
        end
        nblank = 0;
        for (int a = 0; a < 4800; a++) if (vram[a] === 8'h20) nblank++;
        n_cmp++;
        if (nblank != 4800) begin
            n_bad++;
            $display("FAIL clear_contents: %0d blank entries, want 4800", nblank);
        end
    endtask

    task automatic test_back_to_back();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: rdy=%b, want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        step();
        n_cmp++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'd0 || bus.mem_din !== 8'h41 || bus.cursor_x !== 7'd1) begin
            n_bad++;
            $display("FAIL b2b_first: wr=%b addr=%0d din=%h x=%0d, want 1 0 41 1",
                     bus.mem_wr, bus.mem_addr, bus.mem_din, bus.cursor_x);
        end
        bus.in_data = 8'h42;
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'd1 || bus.mem_din !== 8'h42 ||
            bus.cursor_x !== 7'd2 || bus.cursor_y !== 6'd0) begin
            n_bad++;
            $display("FAIL b2b_second: wr=%b addr=%0d din=%h cursor (%0d,%0d), want 1 1 42 (2,0)",
                     bus.mem_wr, bus.mem_addr, bus.mem_din, bus.cursor_x, bus.cursor_y);
        end
        step();
        n_cmp++;
        if (bus.mem_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_write: wr=%b, want 0", bus.mem_wr);
        end
    endtask

    task automatic test_line_wrap();
        int busy_seen;
        for (int i = 0; i < 5; i++) send_byte(8'h0A);
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd5) begin
            n_bad++;
            $display("FAIL lf_move: wr=%b cursor (%0d,%0d), want 0 (0,5)", bus.mem_wr, bus.cursor_x, bus.cursor_y);
        end
        for (int i = 0; i < 79; i++) send_byte(8'h61);
        send_byte(8'h5A);
        n_cmp++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'd479 || bus.mem_din !== 8'h5A ||
            bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd6) begin
            n_bad++;
            $display("FAIL wrap_write: wr=%b addr=%0d din=%h cursor (%0d,%0d), want 1 479 5a (0,6)",
                     bus.mem_wr, bus.mem_addr, bus.mem_din, bus.cursor_x, bus.cursor_y);
        end
        busy_seen = (bus.busy !== 1'b0) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.busy !== 1'b0) busy_seen = 1;
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_bad++;
            $display("FAIL wrap_no_scroll: busy seen=%0d, want 0", busy_seen);
        end
        n_cmp++;
        if (vram[400] !== 8'h61 || vram[478] !== 8'h61 || vram[479] !== 8'h5A) begin
            n_bad++;
            $display("FAIL wrap_contents: [400]=%h [478]=%h [479]=%h, want 61 61 5a", vram[400], vram[478], vram[479]);
        end
    endtask

    task automatic test_backspace();
        int waited;
        send_byte(8'h0C);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.mem_wr !== 1'b0 ||
            bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd0) begin
            n_bad++;
            $display("FAIL ff_t1: busy=%b rdy=%b wr=%b cursor (%0d,%0d), want 1 0 0 (0,0)",
                     bus.busy, bus.in_ready, bus.mem_wr, bus.cursor_x, bus.cursor_y);
        end
        step();
        n_cmp++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'd0 || bus.mem_din !== 8'h20) begin
            n_bad++;
            $display("FAIL ff_t2: wr=%b addr=%0d din=%h, want 1 0 20", bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 6000) begin
            step();
            waited++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ff_timeout: rdy=%b after %0d cycles, want 1", bus.in_ready, waited);
        end
        step();
        send_byte(8'h0A);
        send_byte(8'h0A);
        send_byte(8'h78);
        send_byte(8'h79);
        send_byte(8'h7A);
        n_cmp++;
        if (bus.cursor_x !== 7'd3 || bus.cursor_y !== 6'd2) begin
            n_bad++;
            $display("FAIL bs_setup: cursor (%0d,%0d), want (3,2)", bus.cursor_x, bus.cursor_y);
        end
        send_byte(8'h08);
        n_cmp++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'd162 || bus.mem_din !== 8'h20 || bus.cursor_x !== 7'd2) begin
            n_bad++;
            $display("FAIL bs_write: wr=%b addr=%0d din=%h x=%0d, want 1 162 20 2",
                     bus.mem_wr, bus.mem_addr, bus.mem_din, bus.cursor_x);
        end
        send_byte(8'h0D);
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.cursor_x !== 7'd0) begin
            n_bad++;
            $display("FAIL cr: wr=%b x=%0d, want 0 0", bus.mem_wr, bus.cursor_x);
        end
        send_byte(8'h08);
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd2) begin
            n_bad++;
            $display("FAIL bs_at_col0: wr=%b cursor (%0d,%0d), want 0 (0,2)", bus.mem_wr, bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_scroll();
        int busy_cnt;
        int nblank;
        step();
        for (int i = 0; i < 57; i++) send_byte(8'h0A);
        n_cmp++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd59 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL scroll_setup: cursor (%0d,%0d) busy=%b, want (0,59) 0", bus.cursor_x, bus.cursor_y, bus.busy);
        end
        bd_we = 1'b1; bd_addr = 13'd80;   bd_data = 8'h55; step();
        bd_addr = 13'd4799; bd_data = 8'h77; step();
        bd_we = 1'b0;
        send_byte(8'h0A);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.mem_wr !== 1'b0 ||
            bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd59) begin
            n_bad++;
            $display("FAIL scroll_t1: busy=%b rdy=%b wr=%b cursor (%0d,%0d), want 1 0 0 (0,59)",
                     bus.busy, bus.in_ready, bus.mem_wr, bus.cursor_x, bus.cursor_y);
        end
        step();
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.mem_addr !== 13'd80) begin
            n_bad++;
            $display("FAIL scroll_first_rd: wr=%b addr=%0d, want 0 80", bus.mem_wr, bus.mem_addr);
        end
        step();
        n_cmp++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'd0 || bus.mem_din !== 8'h55) begin
            n_bad++;
            $display("FAIL scroll_first_wr: wr=%b addr=%0d din=%h, want 1 0 55", bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        busy_cnt = 3;
        for (int i = 0; i < 12000; i++) begin
            step();
            if (bus.busy !== 1'b1) break;
            busy_cnt++;
        end
        n_cmp++;
        if (busy_cnt != 9520) begin
            n_bad++;
            $display("FAIL scroll_busy_len: %0d cycles, want 9520", busy_cnt);
        end
        step();
        n_cmp++;
        if (vram[0] !== 8'h55 || vram[4719] !== 8'h77 || vram[80] !== 8'h78 || vram[81] !== 8'h79) begin
            n_bad++;
            $display("FAIL scroll_moved: [0]=%h [4719]=%h [80]=%h [81]=%h, want 55 77 78 79",
                     vram[0], vram[4719], vram[80], vram[81]);
        end
        nblank = 0;
        for (int a = 4720; a < 4800; a++) if (vram[a] === 8'h20) nblank++;
        n_cmp++;
        if (nblank != 80 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd59) begin
            n_bad++;
            $display("FAIL scroll_last_row: %0d blanks cursor (%0d,%0d), want 80 (0,59)",
                     nblank, bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int bad_k;
        int nblank;
        send_byte(8'h0A);
        for (int i = 0; i < 3000; i++) step();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midscroll_busy: busy=%b, want 1", bus.busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (bus.mem_wr !== 1'b0 || bus.mem_addr !== 13'd0 || bus.busy !== 1'b1 ||
            bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd0) begin
            n_bad++;
            $display("FAIL midscroll_reset: wr=%b addr=%0d busy=%b cursor (%0d,%0d), want 0 0 1 (0,0)",
                     bus.mem_wr, bus.mem_addr, bus.busy, bus.cursor_x, bus.cursor_y);
        end
        bad_k = -1;
        for (int k = 0; k < 4800; k++) begin
            step();
            if (bad_k < 0 && (bus.mem_wr !== 1'b1 || bus.mem_addr !== 13'(k) || bus.mem_din !== 8'h20))
                bad_k = k;
        end
        n_cmp++;
        if (bad_k != -1 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midscroll_clear: first bad index %0d rdy=%b, want -1 1", bad_k, bus.in_ready);
        end
        step();
        nblank = 0;
        for (int a = 0; a < 4800; a++) if (vram[a] === 8'h20) nblank++;
        n_cmp++;
        if (nblank != 4800 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 6'd0) begin
            n_bad++;
            $display("FAIL midscroll_final: %0d blanks cursor (%0d,%0d), want 4800 (0,0)",
                     nblank, bus.cursor_x, bus.cursor_y);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #2;
        test_reset();
        test_back_to_back();
        test_line_wrap();
        test_backspace();
        test_scroll();
        test_reset_mid_scroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_console_writer.md
Name: vram_console_writer

Overview:
- Character-terminal front end for the 80x60 text VRAM; owns VRAM port A (write/read side).
- Accepts a byte stream over a valid/ready handshake and interprets control codes.
- Writes glyph codes at the cursor, tracks the cursor, and performs clear-screen and one-line scroll by copying VRAM contents through the same port.

Parameters:
COLS, 80, characters per row
ROWS, 60, rows per screen; COLS*ROWS = 4800 VRAM entries
DATA, 8, character code width
ADDR, 13, VRAM address width
BLANK, 8'h20, fill code for clear/scroll/backspace

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input byte valid
in_data  in  DATA  input byte
in_ready  out  1  block accepts byte this cycle
mem_wr  out  1  VRAM port A write enable
mem_addr  out  ADDR  VRAM port A address
mem_din  out  DATA  VRAM port A write data
mem_dout  in  DATA  VRAM port A read data; valid the cycle after its address is presented
cursor_x  out  7  cursor column, 0..COLS-1
cursor_y  out  6  cursor row, 0..ROWS-1
busy  out  1  clear or scroll in progress

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_BLANK.
- Reset:
  - Outputs: mem_wr=0, mem_addr=0, mem_din=BLANK, cursor (0,0), busy=1, in_ready=0.
  - Next state is CLEAR.
  - Reset asserted in any state aborts the current operation and restarts CLEAR from addr 0.
- Handshake:
  - in_ready = (state==IDLE); transfer occurs when in_valid && in_ready.
  - Back-to-back transfers are allowed in IDLE.
- Accepted byte in cycle t; cursor outputs update at t+1. Per code:
  - Printable (0x20..0x7E):
    - Write at t+1: mem_wr=1, mem_addr=y*COLS+x using the pre-update cursor, mem_din=byte.
    - Cursor: x+1. At x==COLS-1: x=0, then y+1; if y==ROWS-1, scroll instead and y stays ROWS-1.
  - 0x0A LF: x=0. If y<ROWS-1, y+1 and no write; else scroll.
  - 0x0D CR: x=0, no write.
  - 0x08 BS:
    - If x>0: x-1, write BLANK at the new position at t+1.
    - If x==0: no effect.
  - 0x0C FF: cursor (0,0), CLEAR.
  - All other codes: accepted, no effect.
- Timing of multi-cycle operations:
  - When a byte triggers scroll or clear, busy and !in_ready from t+1.
  - The first scroll/clear access is at t+2; cycle t+1 carries only the byte's own write, if any.
- CLEAR: one write per cycle, mem_wr=1, mem_din=BLANK, addr 0..COLS*ROWS-1 ascending (4800 cycles), then IDLE with cursor (0,0).
- Scroll, for src = COLS..COLS*ROWS-1 ascending:
  - SCROLL_RD cycle: mem_wr=0, mem_addr=src.
  - SCROLL_WR cycle: mem_wr=1, mem_addr=src-COLS, mem_din equals mem_dout in that cycle.
  - 2 cycles per character, 9440 cycles total.
- SCROLL_BLANK: COLS writes of BLANK at addr COLS*(ROWS-1)..COLS*ROWS-1 (80 cycles), then IDLE.
  - Total scroll busy = 9520 cycles; cursor (0,ROWS-1).
- mem_wr=0 in every IDLE cycle without a pending write.
- Address arithmetic: y*COLS+x computed in ADDR bits, never exceeds COLS*ROWS-1.
- Wrap and overflow:
  - Never wraps to row 0; overflow always scrolls.
  - cursor_x never equals COLS.

Test Plan:
1. Pulse rst for 1 cycle -> busy=1 and in_ready=0 for exactly 4800 cycles; writes of 0x20 to addr 0..4799 in order; then in_ready=1, cursor (0,0).
2. After clear, send 'A','B' on consecutive cycles -> mem_wr=1 with 0x41@0, then 0x42@1 on consecutive cycles; cursor_x=2, cursor_y=0.
3. Send 5 LF then 79x 'a', then 'Z' -> 0x5A written at addr 479; cursor (0,6); no scroll (busy stays 0).
4. At cursor (3,2), send BS -> write 0x20@162, cursor_x=2. Send CR then BS -> no write, cursor (0,2).
5. Preload VRAM addr 80=0x55 and 4799=0x77; cursor at row 59; send LF -> busy 9520 cycles.
   - Result: addr 0=0x55, addr 4719=0x77, addr 4720..4799=0x20, cursor (0,59).
6. Assert rst mid-scroll (~cycle 3000 of the scroll) -> next cycle CLEAR restarts at addr 0; 4800 clear writes; final VRAM all 0x20, cursor (0,0).
